ball_centroid_stage1: RTL and testbench
=======================================

Name: ball_centroid_stage1

Overview:
- Upstream neighbour of the polar (magnitude/arctan) stage; produces its M/N operands.
- Accumulates x/y coordinates of ball-classified pixels over one video frame.
- At frame end, divides the sums by the pixel count to get the centroid, subtracts the setpoint, and emits the scaled error vector with a one-cycle enable pulse.

Parameters:
- SUM_W, 30, coordinate-sum width (1024x768 worst case); also the divider iteration count.
- CNT_W, 20, pixel-count width.
- MIN_PIXELS, 16, minimum count for a valid detection.
- SCALE_SHIFT, 4, left shift applied to dx/dy before output.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- hcount  in  11  pixel x coordinate.
- vcount  in  10  pixel y coordinate.
- pixel_valid  in  1  active-video qualifier.
- ball_pixel  in  1  pixel classified as ball.
- frame_end  in  1  one-cycle pulse marking the last pixel of the frame.
- set_x  in  11  x setpoint.
- set_y  in  10  y setpoint.
- M  out  14  |dx| << SCALE_SHIFT, unsigned.
- N  out  15  dy << SCALE_SHIFT, signed two's complement.
- x_neg  out  1  dx < 0 (quadrant flag for downstream).
- valid  out  1  one-cycle pulse; M/N/x_neg are stable from this cycle until the next pulse.
- no_ball  out  1  last frame had count < MIN_PIXELS; level output.
- busy  out  1  division in progress.

Behaviour:
- Reset: M=0, N=0, x_neg=0, valid=0, no_ball=0, busy=0; accumulators cleared; FSM to IDLE.
- Accumulate, every cycle: if pixel_valid&&ball_pixel, then sum_x += hcount, sum_y += vcount, count += 1.
- frame_end in IDLE: snapshot {sum_x, sum_y, count}, including any pixel on the same cycle.
  - Clear the accumulators the next cycle.
  - If count < MIN_PIXELS: set no_ball=1, no valid, remain IDLE.
  - Otherwise: clear no_ball, go to DIV_X.
- FSM states: IDLE, DIV_X, DIV_Y, EMIT.
  - DIV_X: restoring division sum_x/count, SUM_W cycles, 1 quotient bit per cycle, quotient truncated (floor).
  - DIV_Y: same for sum_y.
  - EMIT: compute dx = cx - set_x and dy = cy - set_y (12-bit signed); M = |dx| << SCALE_SHIFT; N = dy << SCALE_SHIFT; x_neg = dx[11]; pulse valid; return to IDLE.
- Latency: valid is high exactly 2*SUM_W+3 cycles after the cycle frame_end is sampled (63 at defaults).
- busy is high from the cycle after frame_end through the valid cycle.
- frame_end while busy: the frame's result is dropped.
  - Accumulators still clear and accumulation of the next frame continues.
  - Outputs are unaffected.
- Range: |dx| ≤ 1023 and |dy| ≤ 767, so no saturation is needed at SCALE_SHIFT=4. Wider shifts saturate M to 14'h3FFF and N to ±16383.
- M/N hold their values between pulses; the downstream stage samples them on valid.
- Reset mid-division aborts cleanly: no valid pulse, all outputs return to reset values.

Optional Feature:
- CENTROID_IIR_EN defined:
  - Quotients feed a first-order filter: c_f <= c_f + ((c_new - c_f) >>> 2), signed arithmetic, kept in 13-bit with 2 fraction bits.
  - dx/dy use the integer part of c_f.
  - The first valid frame after reset loads c_f directly.
  - Adds 1 cycle of latency (2*SUM_W+4).
- Undefined: raw quotients are used directly.

Decomposition:
- Shared package ball_plate_pkg holds:
  - FSM state enum.
  - Frame geometry constants: H_ACTIVE=1024, V_ACTIVE=768.
  - Widths SUM_W and CNT_W.
- One natural sub-module: serial_divider (start/done handshake, parameterized dividend/divisor width), instantiated once and reused for x then y.

Test Plan:
- 16 cycles ball_pixel=1 at (600,400), set=(512,384), frame_end -> after 63 cycles valid=1, M=1408, N=256, x_neg=0.
- 16 pixels alternating (100,100)/(101,101), set=(512,384) -> cx=100, cy=100; M=6592, N=-4544, x_neg=1.
- 15 ball pixels then frame_end -> no valid pulse, no_ball=1; next frame with 20 pixels -> valid pulses, no_ball=0.
- Second frame_end 10 cycles after the first -> only one valid pulse, carrying the first frame's result; third frame's result is correct.
- rst asserted 20 cycles into DIV_X -> no valid pulse, M=N=0, busy=0; the next frame processes normally.
- CENTROID_IIR_EN: frame1 cx=600, then frame2 cx=700 (cy fixed) -> second result uses cx=625.

Source files
------------

// File: rtl/ball_plate_pkg.sv
// Shared definitions for the ball/plate vision pipeline: FSM states, frame
// geometry, accumulator widths and the output saturation helpers.
package ball_plate_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;
    localparam int SUM_W    = 30;
    localparam int CNT_W    = 20;

    typedef enum logic [1:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        EMIT
    } state_t;

    // Unsigned magnitude clamped to the 14-bit M range.
    function automatic logic [13:0] sat_mag14(input int v);
        logic [13:0] r;
        r = (v > 16383) ? 14'h3FFF : 14'(v);
        return r;
    endfunction

    // Signed value clamped to +/-16383 for the 15-bit N output.
    function automatic logic signed [14:0] sat_s15(input int v);
        logic signed [14:0] r;
        if (v > 16383)
            r = 15'sd16383;
        else if (v < -16383)
            r = -15'sd16383;
        else
            r = 15'(v);
        return r;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, DVD_W cycles after
// start, with a one-cycle done pulse; the quotient holds until the next start.
module serial_divider #(
    parameter int DVD_W = 30,
    parameter int DVS_W = 20
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             done
);

    localparam int IW = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [IW-1:0]    iter;
    logic [DVS_W:0]   trial;
    logic [DVS_W-1:0] diff;
    logic             fits;

    // NOTE: always_comb assigns every output on every path, so no latch is inferred.
    always_comb begin
        trial = {rem, quotient[DVD_W-1]};
        fits  = (trial >= {1'b0, dvs});
        // When the trial fits, the true difference is below dvs, so the
        // modular DVS_W-bit subtraction is exact.
        diff  = trial[DVS_W-1:0] - dvs;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (rst) begin
            quotient <= '0;
            rem      <= '0;
            dvs      <= '0;
            iter     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient <= dividend;
                rem      <= '0;
                dvs      <= divisor;
                iter     <= IW'(DVD_W);
            end else if (iter != '0) begin
                iter     <= iter - 1'b1;
                rem      <= fits ? diff : trial[DVS_W-1:0];
                quotient <= {quotient[DVD_W-2:0], fits};
                done     <= (iter == IW'(1));
            end
        end
    end

endmodule

// File: rtl/ball_centroid_stage1.sv
// Per-frame ball centroid and scaled setpoint error for the polar stage.
// Define CENTROID_IIR_EN to low-pass the centroid across frames (+1 cycle latency).
module ball_centroid_stage1 #(
    parameter int SUM_W       = ball_plate_pkg::SUM_W,
    parameter int CNT_W       = ball_plate_pkg::CNT_W,
    parameter int MIN_PIXELS  = 16,
    parameter int SCALE_SHIFT = 4
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [10:0]        hcount,
    input  logic [9:0]         vcount,
    input  logic               pixel_valid,
    input  logic               ball_pixel,
    input  logic               frame_end,
    input  logic [10:0]        set_x,
    input  logic [9:0]         set_y,
    output logic [13:0]        M,
    output logic signed [14:0] N,
    output logic               x_neg,
    output logic               valid,
    output logic               no_ball,
    output logic               busy
);

    import ball_plate_pkg::state_t, ball_plate_pkg::IDLE, ball_plate_pkg::DIV_X;
    import ball_plate_pkg::DIV_Y, ball_plate_pkg::EMIT, ball_plate_pkg::H_ACTIVE;
    import ball_plate_pkg::V_ACTIVE, ball_plate_pkg::sat_mag14, ball_plate_pkg::sat_s15;

    state_t state, state_nxt;

    logic [SUM_W-1:0] sum_x, sum_y, tot_x, tot_y, snap_y;
    logic [CNT_W-1:0] count, tot_cnt, snap_cnt;
    logic             hit, accept, enough;

    logic             div_start, div_done;
    logic [SUM_W-1:0] div_dividend, div_q;
    logic [CNT_W-1:0] div_divisor;

    logic [9:0]        qx, cx_q, cy_q;
    logic [10:0]       cx_use;
    logic [9:0]        cy_use;
    logic signed [11:0] dx, dy;
    logic [11:0]       mag;
    logic              emit_fire;

    assign busy = (state != IDLE) || valid;

    always_comb begin
        hit     = pixel_valid && ball_pixel;
        tot_x   = sum_x + (hit ? SUM_W'(hcount) : '0);
        tot_y   = sum_y + (hit ? SUM_W'(vcount) : '0);
        tot_cnt = count + CNT_W'(hit);
        accept  = frame_end && !busy;
        enough  = (tot_cnt >= CNT_W'(MIN_PIXELS));

        // The single divider runs x first, then is reloaded with the stored y sum.
        div_start    = (accept && enough) || (state == DIV_X && div_done);
        div_dividend = (state == DIV_X) ? snap_y : tot_x;
        div_divisor  = (state == DIV_X) ? snap_cnt : tot_cnt;

        // A centroid always lies inside the active frame; clamp keeps the narrow path honest.
        cx_q = (div_q > SUM_W'(H_ACTIVE - 1)) ? 10'(H_ACTIVE - 1) : div_q[9:0];
        cy_q = (div_q > SUM_W'(V_ACTIVE - 1)) ? 10'(V_ACTIVE - 1) : div_q[9:0];
    end

    serial_divider #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clock    (clock),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_q),
        .done     (div_done)
    );

`ifdef CENTROID_IIR_EN
    logic signed [12:0] cf_x, cf_y, cn_x, cn_y, df_x, df_y;
    logic               cf_loaded, filt_done;

    always_comb begin
        cn_x = $signed({1'b0, qx, 2'b00});
        cn_y = $signed({1'b0, cy_q, 2'b00});
        df_x = cn_x - cf_x;
        df_y = cn_y - cf_y;
    end

    // EMIT spends its first cycle updating the filter, its second producing outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            cf_x      <= '0;
            cf_y      <= '0;
            cf_loaded <= 1'b0;
            filt_done <= 1'b0;
        end else if (state == EMIT) begin
            if (!filt_done) begin
                cf_x      <= cf_loaded ? cf_x + (df_x >>> 2) : cn_x;
                cf_y      <= cf_loaded ? cf_y + (df_y >>> 2) : cn_y;
                cf_loaded <= 1'b1;
                filt_done <= 1'b1;
            end else begin
                filt_done <= 1'b0;
            end
        end
    end

    assign emit_fire = (state == EMIT) && filt_done;
    assign cx_use    = cf_x[12:2];
    assign cy_use    = cf_y[11:2];
`else
    assign emit_fire = (state == EMIT);
    assign cx_use    = {1'b0, qx};
    assign cy_use    = cy_q;
`endif

    always_comb begin
        dx  = $signed({1'b0, cx_use}) - $signed({1'b0, set_x});
        dy  = $signed({2'b00, cy_use}) - $signed({2'b00, set_y});
        mag = dx[11] ? -dx : dx;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && enough) state_nxt = DIV_X;
            DIV_X:   if (div_done)         state_nxt = DIV_Y;
            DIV_Y:   if (div_done)         state_nxt = EMIT;
            EMIT:    if (emit_fire)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            sum_x    <= '0;
            sum_y    <= '0;
            count    <= '0;
            snap_y   <= '0;
            snap_cnt <= '0;
            qx       <= '0;
            M        <= '0;
            N        <= '0;
            x_neg    <= 1'b0;
            valid    <= 1'b0;
            no_ball  <= 1'b0;
        end else begin
            valid <= 1'b0;
            // Every frame_end restarts accumulation, even when its frame is dropped.
            if (frame_end) begin
                sum_x <= '0;
                sum_y <= '0;
                count <= '0;
            end else begin
                sum_x <= tot_x;
                sum_y <= tot_y;
                count <= tot_cnt;
            end
            if (accept) begin
                no_ball  <= !enough;
                snap_y   <= tot_y;
                snap_cnt <= tot_cnt;
            end
            if (state == DIV_X && div_done)
                qx <= cx_q;
            if (emit_fire) begin
                M     <= sat_mag14(int'(mag) << SCALE_SHIFT);
                N     <= sat_s15(int'(dy) <<< SCALE_SHIFT);
                x_neg <= dx[11];
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ball_centroid_stage1.sv
// Bench for ball_centroid_stage1 (default build): table-driven frames with a
// result scoreboard checked on each valid pulse, plus drop and abort sequences.
module tb_ball_centroid_stage1;

    localparam int LAT = 63;

    logic               clock = 1'b0;
    logic               rst = 1'b1;
    logic [10:0]        hcount = '0;
    logic [9:0]         vcount = '0;
    logic               pixel_valid = 1'b0;
    logic               ball_pixel = 1'b0;
    logic               frame_end = 1'b0;
    logic [10:0]        set_x = '0;
    logic [9:0]         set_y = '0;
    logic [13:0]        M;
    logic signed [14:0] N;
    logic               x_neg, valid, no_ball, busy;

    always #5 clock = ~clock;

    ball_centroid_stage1 dut (
        .clock       (clock),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .pixel_valid (pixel_valid),
        .ball_pixel  (ball_pixel),
        .frame_end   (frame_end),
        .set_x       (set_x),
        .set_y       (set_y),
        .M           (M),
        .N           (N),
        .x_neg       (x_neg),
        .valid       (valid),
        .no_ball     (no_ball),
        .busy        (busy)
    );

    typedef struct {
        int x0; int y0; int x1; int y1; int n; int sx; int sy;
        bit acc; int m; int nv; bit xneg; bit nob;
    } vec_t;

    typedef struct {
        int m; int nv; bit xneg; int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fe, fe2, hold_m;
    logic prev_valid = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int m, input int nv, input bit xneg, input int due);
        exp_t e;
        e.m = m; e.nv = nv; e.xneg = xneg; e.due = due;
        sb.push_back(e);
    endtask

    // n ball pixels alternating between two points; the last one carries frame_end.
    // Non-ball and non-valid distractor cycles are mixed in and must be ignored.
    task automatic drive_frame(input int x0, input int y0, input int x1, input int y1,
                               input int n, output int fe_cyc);
        fe_cyc = 0;
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 1) begin
                @(negedge clock);
                hcount = 11'd2047; vcount = 10'd1023;
                pixel_valid = 1'b1; ball_pixel = 1'b0; frame_end = 1'b0;
                @(negedge clock);
                pixel_valid = 1'b0; ball_pixel = 1'b1;
            end
            @(negedge clock);
            hcount      = 11'((i % 2 == 1) ? x1 : x0);
            vcount      = 10'((i % 2 == 1) ? y1 : y0);
            pixel_valid = 1'b1;
            ball_pixel  = 1'b1;
            frame_end   = (i == n - 1);
            if (i == n - 1) fe_cyc = cyc + 1;
        end
        @(negedge clock);
        pixel_valid = 1'b0; ball_pixel = 1'b0; frame_end = 1'b0;
    endtask

    // Scoreboard side: every valid pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (!rst) begin
            if (prev_valid) check("busy_after_valid", int'(busy), 0);
            if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected no pulse", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("M", int'(M), mon_e.m);
                    check("N", int'(N), mon_e.nv);
                    check("x_neg", int'(x_neg), int'(mon_e.xneg));
                    check("latency", cyc, mon_e.due);
                    check("busy_on_valid", int'(busy), 1);
                end
            end
        end
        prev_valid <= valid;
    end

    initial begin
        vecs[0] = '{600, 400, 600, 400, 16, 512, 384, 1'b1, 1408, 256, 1'b0, 1'b0};
        vecs[1] = '{100, 100, 101, 101, 16, 512, 384, 1'b1, 6592, -4544, 1'b1, 1'b0};
        vecs[2] = '{600, 400, 600, 400, 15, 512, 384, 1'b0, 0, 0, 1'b0, 1'b1};
        vecs[3] = '{300, 700, 300, 700, 20, 512, 384, 1'b1, 3392, 5056, 1'b1, 1'b0};
        vecs[4] = '{0, 0, 0, 0, 16, 1023, 767, 1'b1, 16368, -12272, 1'b1, 1'b0};
        vecs[5] = '{1023, 767, 1023, 767, 16, 0, 0, 1'b1, 16368, 12272, 1'b0, 1'b0};
        vecs[6] = '{512, 384, 512, 384, 16, 512, 384, 1'b1, 0, 0, 1'b0, 1'b0};
        hold_m = 0;

        repeat (3) @(negedge clock);
        check("rst_M", int'(M), 0);
        check("rst_N", int'(N), 0);
        check("rst_x_neg", int'(x_neg), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_no_ball", int'(no_ball), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            set_x = 11'(vecs[k].sx);
            set_y = 10'(vecs[k].sy);
            drive_frame(vecs[k].x0, vecs[k].y0, vecs[k].x1, vecs[k].y1, vecs[k].n, fe);
            if (vecs[k].acc) push_exp(vecs[k].m, vecs[k].nv, vecs[k].xneg, fe + LAT);
            check("busy_after_frame_end", int'(busy), int'(vecs[k].acc));
            check("no_ball", int'(no_ball), int'(vecs[k].nob));
            repeat (70) @(negedge clock);
            check("drain", sb.size(), 0);
            if (vecs[k].acc) hold_m = vecs[k].m;
            else             check("hold_M", int'(M), hold_m);
        end

        // Second frame_end while the first frame is still dividing is dropped.
        set_x = 11'd512; set_y = 10'd384;
        drive_frame(600, 400, 600, 400, 16, fe);
        push_exp(1408, 256, 1'b0, fe + LAT);
        drive_frame(50, 50, 50, 50, 7, fe2);
        check("busy_at_dropped_end", int'(busy), 1);
        check("no_ball_at_dropped_end", int'(no_ball), 0);
        repeat (70) @(negedge clock);
        check("drain_drop", sb.size(), 0);
        check("hold_after_drop", int'(M), 1408);
        drive_frame(200, 300, 200, 300, 16, fe);
        push_exp(4992, -1344, 1'b1, fe + LAT);
        repeat (70) @(negedge clock);
        check("drain_third", sb.size(), 0);

        // Reset twenty cycles into DIV_X aborts without a pulse.
        drive_frame(600, 400, 600, 400, 16, fe);
        repeat (20) @(negedge clock);
        check("busy_in_div_x", int'(busy), 1);
        rst = 1'b1;
        @(negedge clock);
        check("abort_M", int'(M), 0);
        check("abort_N", int'(N), 0);
        check("abort_x_neg", int'(x_neg), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid), 0);
        rst = 1'b0;
        repeat (70) @(negedge clock);
        check("drain_abort", sb.size(), 0);
        check("M_after_abort", int'(M), 0);

        drive_frame(600, 400, 600, 400, 16, fe);
        push_exp(1408, 256, 1'b0, fe + LAT);
        repeat (70) @(negedge clock);
        check("drain_recover", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
